// File: rtl/pcie_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// pcie_mem_arbiter_if
//   Bundles every bus signal of the two-requester memory arbiter. Signal names
//   carry the arbiter's own direction (i_ = into the arbiter, o_ = out of it).
//
//   Requester side (packed per requester, requester n in slice n):
//     i_req_valid/write/last [1:0], i_req_bytes [19:0], i_req_addr [25:0],
//     i_req_strob [15:0], i_req_data [127:0], o_req_ready [1:0]
//     o_resp_valid [1:0], o_resp_last/fault, o_resp_addr [12:0],
//     o_resp_data [63:0], i_resp_ready [1:0], o_resp_orphan
//   Memory side:
//     o_mem_valid/write/last, o_mem_bytes [9:0], o_mem_addr [12:0],
//     o_mem_strob [7:0], o_mem_data [63:0], i_mem_ready,
//     i_mem_resp_valid/last/fault, i_mem_resp_addr [12:0],
//     i_mem_resp_data [63:0], o_mem_resp_ready
//
//   modport slave  : the arbiter
//   modport master : whatever drives the arbiter (requesters + memory model)
// ---------------------------------------------------------------------------
interface pcie_mem_arbiter_if;
  logic [1:0]   i_req_valid;
  logic [1:0]   o_req_ready;
  logic [1:0]   i_req_write;
  logic [19:0]  i_req_bytes;
  logic [25:0]  i_req_addr;
  logic [15:0]  i_req_strob;
  logic [127:0] i_req_data;
  logic [1:0]   i_req_last;

  logic [1:0]   o_resp_valid;
  logic         o_resp_last;
  logic         o_resp_fault;
  logic [12:0]  o_resp_addr;
  logic [63:0]  o_resp_data;
  logic [1:0]   i_resp_ready;

  logic         i_mem_ready;
  logic         o_mem_valid;
  logic         o_mem_write;
  logic [9:0]   o_mem_bytes;
  logic [12:0]  o_mem_addr;
  logic [7:0]   o_mem_strob;
  logic [63:0]  o_mem_data;
  logic         o_mem_last;

  logic         i_mem_resp_valid;
  logic         i_mem_resp_last;
  logic         i_mem_resp_fault;
  logic [12:0]  i_mem_resp_addr;
  logic [63:0]  i_mem_resp_data;
  logic         o_mem_resp_ready;
  logic         o_resp_orphan;

  modport slave (
    input  i_req_valid, i_req_write, i_req_bytes, i_req_addr, i_req_strob,
           i_req_data, i_req_last, i_resp_ready, i_mem_ready,
           i_mem_resp_valid, i_mem_resp_last, i_mem_resp_fault,
           i_mem_resp_addr, i_mem_resp_data,
    output o_req_ready, o_resp_valid, o_resp_last, o_resp_fault, o_resp_addr,
           o_resp_data, o_mem_valid, o_mem_write, o_mem_bytes, o_mem_addr,
           o_mem_strob, o_mem_data, o_mem_last, o_mem_resp_ready, o_resp_orphan
  );

  modport master (
    output i_req_valid, i_req_write, i_req_bytes, i_req_addr, i_req_strob,
           i_req_data, i_req_last, i_resp_ready, i_mem_ready,
           i_mem_resp_valid, i_mem_resp_last, i_mem_resp_fault,
           i_mem_resp_addr, i_mem_resp_data,
    input  o_req_ready, o_resp_valid, o_resp_last, o_resp_fault, o_resp_addr,
           o_resp_data, o_mem_valid, o_mem_write, o_mem_bytes, o_mem_addr,
           o_mem_strob, o_mem_data, o_mem_last, o_mem_resp_ready, o_resp_orphan
  );
endinterface

// File: rtl/pcie_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_mem_arbiter
//   Round-robin arbiter that lets two requesters (0 = PCIe IO endpoint,
//   1 = local agent) share one 13-bit-address memory port. A grant covers a
//   whole request sequence up to its last beat. The owner of every completed
//   sequence is pushed into an in-order tag FIFO; since memory answers in
//   order, the FIFO head tells which requester the current response belongs to.
//
//   Ports:
//     i_clk   : system bus clock
//     i_nrst  : asynchronous active-low reset
//     bus     : pcie_mem_arbiter_if.slave (requester, response and memory buses)
//   Parameter:
//     OUTSTANDING_DEPTH : max sequences awaiting their response last beat
//                         (power of 2, >= 2)
// ---------------------------------------------------------------------------
module pcie_mem_arbiter #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  pcie_mem_arbiter_if.slave bus
);
  localparam int PW = $clog2(OUTSTANDING_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTSTANDING_DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_rr_ptr;
  logic          r_orphan;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_tag [OUTSTANDING_DEPTH];

  logic w_empty, w_full, w_head;
  logic w_grant, w_grant_owner;
  logic w_sel_valid, w_sel_last;
  logic w_push, w_pop, w_orphan, w_mem_resp_ready;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_head  = r_tag[r_rd_ptr];

  // Arbitration: a tie is broken by rr_ptr, otherwise the lone requester wins.
  assign w_grant       = (r_state == IDLE) && (|bus.i_req_valid) && !w_full;
  assign w_grant_owner = (&bus.i_req_valid) ? r_rr_ptr : bus.i_req_valid[1];

  assign w_sel_valid = bus.i_req_valid[r_owner];
  assign w_sel_last  = bus.i_req_last[r_owner];
  assign w_push      = (r_state == BURST) && w_sel_valid && bus.i_mem_ready && w_sel_last;

  // Request path: the owner's fields are forwarded only while a burst is
  // granted, so the memory port sits at all-zero between grants.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    bus.o_mem_valid = 1'b0;
    bus.o_mem_write = 1'b0;
    bus.o_mem_bytes = '0;
    bus.o_mem_addr  = '0;
    bus.o_mem_strob = '0;
    bus.o_mem_data  = '0;
    bus.o_mem_last  = 1'b0;
    bus.o_req_ready = 2'b00;
    if (r_state == BURST) begin
      bus.o_mem_valid = w_sel_valid;
      bus.o_mem_write = bus.i_req_write[r_owner];
      bus.o_mem_last  = w_sel_last;
      bus.o_req_ready = r_owner ? {bus.i_mem_ready, 1'b0} : {1'b0, bus.i_mem_ready};
      bus.o_mem_bytes = r_owner ? bus.i_req_bytes[19:10]  : bus.i_req_bytes[9:0];
      bus.o_mem_addr  = r_owner ? bus.i_req_addr[25:13]   : bus.i_req_addr[12:0];
      bus.o_mem_strob = r_owner ? bus.i_req_strob[15:8]   : bus.i_req_strob[7:0];
      bus.o_mem_data  = r_owner ? bus.i_req_data[127:64]  : bus.i_req_data[63:0];
    end
  end

  // Response path: steered by the FIFO head. With nothing outstanding the
  // beat is swallowed (ready follows valid) and flagged as an orphan.
  assign w_mem_resp_ready = w_empty ? bus.i_mem_resp_valid : bus.i_resp_ready[w_head];
  assign w_pop    = !w_empty && bus.i_mem_resp_valid && w_mem_resp_ready && bus.i_mem_resp_last;
  assign w_orphan = w_empty && bus.i_mem_resp_valid;

  assign bus.o_resp_valid     = w_empty ? 2'b00
                              : (w_head ? {bus.i_mem_resp_valid, 1'b0} : {1'b0, bus.i_mem_resp_valid});
  assign bus.o_mem_resp_ready = w_mem_resp_ready;
  assign bus.o_resp_last      = bus.i_mem_resp_last;
  assign bus.o_resp_fault     = bus.i_mem_resp_fault;
  assign bus.o_resp_addr      = bus.i_mem_resp_addr;
  assign bus.o_resp_data      = bus.i_mem_resp_data;
  assign bus.o_resp_orphan    = r_orphan;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_orphan <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_orphan <= w_orphan;
      case (r_state)
        IDLE: if (w_grant) begin
          r_owner <= w_grant_owner;
          r_state <= BURST;
        end
        BURST: if (w_push) begin
          r_rr_ptr <= ~r_owner;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Pointers wrap naturally since the depth is a power of 2.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the tag storage has no reset; entries are only read between a push
  // and its pop, and the reset-cleared count guards that.
  always_ff @(posedge i_clk) begin
    if (w_push) r_tag[r_wr_ptr] <= r_owner;
  end
endmodule

// File: doc/pcie_mem_arbiter.md
Name: pcie_mem_arbiter

Overview:
- Two-requester arbiter in front of the 13-bit-address memory request/response interface that the PCIe IO endpoint drives.
- Requester 0 is the PCIe IO endpoint; requester 1 is a local agent, e.g. a DMA or debug port.
- Grants whole request sequences (up to and including the beat with last) using round-robin priority.
- Records sequence ownership in an in-order tag FIFO, so every response sequence is steered back to the requester that issued it.

Parameters:
OUTSTANDING_DEPTH, 4, max request sequences in flight awaiting a response last beat (power of 2, >=2)

Ports:
i_clk  in  1  system bus clock
i_nrst  in  1  asynchronous active-low reset
i_req_valid  in  2  per-requester request valid, bit n = requester n
o_req_ready  out  2  per-requester request accept
i_req_write  in  2  per-requester 0=read, 1=write
i_req_bytes  in  20  10 bits per requester, 0=1024 B
i_req_addr  in  26  13 bits per requester
i_req_strob  in  16  8 bits per requester, write byte enables
i_req_data  in  128  64 bits per requester, write data
i_req_last  in  2  per-requester last beat of sequence
o_resp_valid  out  2  per-requester response valid
o_resp_last  out  1  shared, last response beat
o_resp_fault  out  1  shared, memory fault
o_resp_addr  out  13  shared, response address
o_resp_data  out  64  shared, read data
i_resp_ready  in  2  per-requester response accept
i_mem_ready  in  1  memory ready for request beat
o_mem_valid  out  1  request beat valid
o_mem_write  out  1  muxed write flag
o_mem_bytes  out  10  muxed byte count
o_mem_addr  out  13  muxed address
o_mem_strob  out  8  muxed byte strobes
o_mem_data  out  64  muxed write data
o_mem_last  out  1  muxed last
i_mem_resp_valid  in  1  memory response valid
i_mem_resp_last  in  1  memory response last beat
i_mem_resp_fault  in  1  memory response fault
i_mem_resp_addr  in  13  memory response address
i_mem_resp_data  in  64  memory response data
o_mem_resp_ready  out  1  response accept to memory
o_resp_orphan  out  1  one-cycle pulse when a response beat arrives with no outstanding sequence

Behaviour:
- Reset (async, i_nrst=0):
  - State=IDLE, owner=0, rr_ptr=0 (requester 0 has priority first), FIFO empty (count=0).
  - All outputs 0, including o_req_ready, o_mem_valid, o_resp_valid and o_resp_orphan.
  - A reset mid-burst abandons the burst and all outstanding tags.
- IDLE:
  - o_mem_valid=0, o_req_ready=0.
  - If any i_req_valid bit is set and count<OUTSTANDING_DEPTH, register owner and go to BURST.
  - Owner selection: if both valid, owner=rr_ptr; otherwise owner=the single valid requester.
  - Arbitration latency is 1 cycle: the first beat can transfer on the cycle after the grant.
- BURST:
  - o_mem_* = fields of requester owner; o_mem_valid=i_req_valid[owner].
  - o_req_ready[owner]=i_mem_ready; the other o_req_ready bit is 0.
  - Beat accepted when o_mem_valid & i_mem_ready.
  - Accepted beat with last=1: push owner into the tag FIFO, set rr_ptr=~owner, return to IDLE.
  - Owner deasserting valid mid-sequence: hold the grant, o_mem_valid=0; no timeout.
  - The FIFO cannot overflow, because a grant requires count<DEPTH and only one sequence is in flight per grant.
- Response routing (combinational from FIFO head; head = owner of the oldest outstanding sequence):
  - o_resp_valid[head]=i_mem_resp_valid & ~empty; the other bit is 0.
  - o_resp_last/fault/addr/data = i_mem_resp_* directly.
  - o_mem_resp_ready=i_resp_ready[head] when not empty.
  - Response beat accepted with last=1 pops the head.
- Empty FIFO with i_mem_resp_valid=1:
  - o_mem_resp_ready=1 and the beat is dropped.
  - o_resp_orphan=1, registered, so it pulses the next cycle.
- Push and pop in the same cycle: count unchanged, pointers both advance; wrap-around is modulo OUTSTANDING_DEPTH.
- Requests of one requester may overtake nothing: memory is in-order, so the FIFO order equals the response order.

Test Plan:
- Requester 0 only, single-beat read to addr 0x010: grant next cycle, o_mem_addr=0x010. Response data 0xDEADBEEF_01234567 with last arrives at o_resp_valid=2'b01; count returns to 0.
- Both valid in the same cycle after reset: requester 0 first sequence (3 beats, last on beat 3), then requester 1. Grants alternate 0,1,0 across three rounds.
- Requester 1 deasserts valid for 2 cycles mid 4-beat write: grant held, o_mem_valid=0 during the gap, requester 0 blocked. 4 beats delivered, then requester 0 granted.
- Issue 4 read sequences with memory responses stalled: 5th valid request is not granted (o_req_ready=0) until the first response last is accepted. Then the grant occurs.
- Response with i_mem_resp_valid=1 and empty FIFO: o_mem_resp_ready=1, o_resp_valid=0, o_resp_orphan pulses for exactly 1 cycle.
- i_nrst low during BURST beat 2 of 4: all outputs 0 immediately. After release, requester 1 is granted cleanly with count=0.
